// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: round-robin, burst-hold arbiter that shares one 2:1 mux
// between two valid/ready requesters and feeds a single-entry registered output stage.
//   Clock, Reset (async, active-high)
//   DataA/ValidA/ReadyA, DataB/ValidB/ReadyB : requester handshakes
//   Select                                   : mux select / current grant (0=A, 1=B)
//   DataOutput/ValidOutput/ReadyOutput       : registered output handshake
//   Define ARB_FIXED_PRIORITY_EN to make A win every both-valid arbitration.
module mux2_stream_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] DataA,
   input  logic                  ValidA,
   output logic                  ReadyA,
   input  logic [DATA_WIDTH-1:0] DataB,
   input  logic                  ValidB,
   output logic                  ReadyB,
   output logic                  Select,
   output logic [DATA_WIDTH-1:0] DataOutput,
   output logic                  ValidOutput,
   input  logic                  ReadyOutput
);
   localparam int CW = $clog2(BURST_LEN + 1);
   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
   state_t state, stateNext;
   logic [CW-1:0] burstCnt, burstCntNext;
   logic [DATA_WIDTH-1:0] dataNext;
   logic lastOwner, lastOwnerNext;
   logic selectHold, validNext;
   logic holdA, holdB, grantHold, grantSel, bothSel, anyValid, canLoad, transfer;
`ifdef ARB_FIXED_PRIORITY_EN
   assign bothSel = 1'b0;
`else
   // lastOwner is 1 for B, so the other requester is simply its complement
   assign bothSel = ~lastOwner;
`endif
   always_comb begin
      holdA = (state == OWN_A) && ValidA && (burstCnt < CW'(BURST_LEN));
      holdB = (state == OWN_B) && ValidB && (burstCnt < CW'(BURST_LEN));
      grantHold = holdA | holdB;
      grantSel = holdA ? 1'b0 : holdB ? 1'b1 : (ValidA & ValidB) ? bothSel : ValidB;
      anyValid = ValidA | ValidB;
      canLoad = !ValidOutput | ReadyOutput;
      // the granted requester is always valid, so any grant with room is a transfer
      transfer = canLoad & anyValid & !Reset;
      Select = Reset ? 1'b0 : anyValid ? grantSel : selectHold;
      ReadyA = transfer & !grantSel;
      ReadyB = transfer & grantSel;
      // an idle cycle with room means no one is valid, so ownership lapses
      stateNext = transfer ? (grantSel ? OWN_B : OWN_A) : canLoad ? IDLE : state;
      // a re-grant after burst expiry comes through arbitration and restarts at 1
      burstCntNext = transfer ? (grantHold ? burstCnt + CW'(1) : CW'(1)) : canLoad ? '0 : burstCnt;
      lastOwnerNext = transfer ? grantSel : lastOwner;
      validNext = transfer | (ValidOutput & !ReadyOutput);
      dataNext = transfer ? (grantSel ? DataB : DataA) : DataOutput;
   end
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         burstCnt <= '0;
         lastOwner <= 1'b1;
         selectHold <= 1'b0;
         ValidOutput <= 1'b0;
         DataOutput <= '0;
      end else begin
         state <= stateNext;
         burstCnt <= burstCntNext;
         lastOwner <= lastOwnerNext;
         selectHold <= Select;
         ValidOutput <= validNext;
         DataOutput <= dataNext;
      end
   end
endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// tb_mux2_stream_arbiter: directed plus randomized checks of mux2_stream_arbiter against a rule-level model and word scoreboard.
module tb_mux2_stream_arbiter;
   localparam int BL = 4;
   logic Clock = 1'b0, Reset = 1'b1;
   logic [31:0] DataA = '0, DataB = '0, DataOutput;
   logic ValidA = 1'b0, ValidB = 1'b0, ReadyOutput = 1'b0;
   logic ReadyA, ReadyB, Select, ValidOutput;
   int nPass = 0, nTotal = 0;
   int mOwner = 0, mCnt = 0, mLast = 2, mAccepted = 0, mConsumed = 0;
   bit mVal = 1'b0, mSel = 1'b0;
   logic [31:0] mData = '0;
   logic [31:0] sb[$];

   mux2_stream_arbiter #(.DATA_WIDTH(32), .BURST_LEN(BL)) dut (
      .Clock(Clock), .Reset(Reset),
      .DataA(DataA), .ValidA(ValidA), .ReadyA(ReadyA),
      .DataB(DataB), .ValidB(ValidB), .ReadyB(ReadyB),
      .Select(Select), .DataOutput(DataOutput), .ValidOutput(ValidOutput), .ReadyOutput(ReadyOutput)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTotal++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // grant by the arbitration rules: 0 none, 1 A, 2 B
   function automatic int expGrant(input bit va, input bit vb);
      if (mOwner == 1 && va && mCnt < BL) return 1;
      if (mOwner == 2 && vb && mCnt < BL) return 2;
`ifdef ARB_FIXED_PRIORITY_EN
      if (va && vb) return 1;
`else
      if (va && vb) return (mLast == 1) ? 2 : 1;
`endif
      if (va) return 1;
      if (vb) return 2;
      return 0;
   endfunction

   task automatic resetModel();
      mOwner = 0; mCnt = 0; mLast = 2; mVal = 0; mSel = 0; mData = '0;
      sb.delete();
   endtask

   task automatic step(input bit va, input logic [31:0] da, input bit vb, input logic [31:0] db, input bit ro);
      int g;
      bit canLoad;
      logic [31:0] w;
      @(negedge Clock);
      ValidA = va; DataA = da; ValidB = vb; DataB = db; ReadyOutput = ro;
      #1;
      g = expGrant(va, vb);
      canLoad = !mVal || ro;
      if (g != 0) mSel = (g == 2);
      check("select", Select, mSel);
      check("readyA", ReadyA, canLoad && g == 1);
      check("readyB", ReadyB, canLoad && g == 2);
      if (mVal && ro) begin
         w = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
         check("scoreboard", DataOutput, w);
         mConsumed++;
      end
      @(posedge Clock);
      if (canLoad && g != 0) begin
         mData = (g == 1) ? da : db;
         mVal = 1;
         mCnt = (g == mOwner && mCnt < BL) ? mCnt + 1 : 1;
         mOwner = g; mLast = g;
         sb.push_back(mData);
         mAccepted++;
      end else begin
         if (mVal && ro) mVal = 0;
         if (canLoad) begin mOwner = 0; mCnt = 0; end
      end
      #1;
      check("validOut", ValidOutput, mVal);
      check("dataOut", DataOutput, mData);
   endtask

   initial begin
      #2;
      check("rst_valid", ValidOutput, 1'b0);
      check("rst_data", DataOutput, 32'h0);
      check("rst_select", Select, 1'b0);
      @(negedge Clock);
      Reset = 1'b0;
      resetModel();
      // single A word
      step(1, 32'hFFFFFFFF, 0, 32'h0, 1);
      step(0, 32'h0, 0, 32'h0, 1);
      step(0, 32'h0, 0, 32'h0, 1);
      // both valid continuously: 4/4 alternation (fixed priority: all A)
      for (int i = 0; i < 16; i++) step(1, 32'hFFFFFFFF, 1, 32'h0, 1);
      check("b_none_fixed_or_rr", ValidOutput, 1'b1);
      // backpressure for 5 cycles, then resume
      for (int i = 0; i < 5; i++) step(1, 32'hA0000000 + i, 1, 32'hB0000000 + i, 0);
      for (int i = 0; i < 6; i++) step(1, 32'hA1000000 + i, 1, 32'hB1000000 + i, 1);
      step(0, 32'h0, 0, 32'h0, 1);
      step(0, 32'h0, 0, 32'h0, 1);
      check("bp_lossless", mConsumed, mAccepted);
      // early release: A owns for 2, then B takes over and holds a full burst
      step(1, 32'h000000A1, 0, 32'h0, 1);
      step(1, 32'h000000A2, 0, 32'h0, 1);
      step(0, 32'h0, 1, 32'h000000B1, 1);
      check("early_sel_b", Select, 1'b1);
      for (int i = 0; i < 5; i++) step(1, 32'h000000A3 + i, 1, 32'h000000B2 + i, 1);
      // randomized traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
      // mid-stream asynchronous reset with a word in flight
      step(1, 32'h12345678, 1, 32'h9ABCDEF0, 0);
      check("pre_rst_valid", ValidOutput, 1'b1);
      @(negedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("arst_valid", ValidOutput, 1'b0);
      check("arst_data", DataOutput, 32'h0);
      check("arst_select", Select, 1'b0);
      check("arst_readyA", ReadyA, 1'b0);
      check("arst_readyB", ReadyB, 1'b0);
      ValidA = 1'b0; ValidB = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
      resetModel();
      mConsumed = 0; mAccepted = 0;
      // A must win the first both-valid arbitration after reset
      step(1, 32'h0000AAAA, 1, 32'h0000BBBB, 1);
      check("post_rst_a_first", DataOutput, 32'h0000AAAA);
      for (int i = 0; i < 8; i++) step(1, 32'h00010000 + i, 1, 32'h00020000 + i, 1);
      step(0, 32'h0, 0, 32'h0, 1);
      step(0, 32'h0, 0, 32'h0, 1);
      check("final_empty", sb.size(), 0);
      check("final_count", mConsumed, mAccepted);
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end
endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Shares one 2:1 DATA_WIDTH-bit mux path between two valid/ready requesters (A, B) and drives the mux `Select`.
- Registers the winner's word into a single-entry output stage with its own valid/ready handshake.
- Round-robin arbitration with burst hold: an owner keeps the grant for up to BURST_LEN consecutive transfers.
- Sits between two producers and one shared 32-bit consumer port.

Parameters:
DATA_WIDTH, 32, width of DataA/DataB/DataOutput
BURST_LEN, 4, max consecutive transfers per grant (>=1)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
DataA  input  DATA_WIDTH  requester A word
ValidA  input  1  A has a word
ReadyA  output  1  A word accepted this cycle when ValidA&ReadyA
DataB  input  DATA_WIDTH  requester B word
ValidB  input  1  B has a word
ReadyB  output  1  B word accepted this cycle when ValidB&ReadyB
Select  output  1  current grant / mux select: 0=A, 1=B
DataOutput  output  DATA_WIDTH  registered output word
ValidOutput  output  1  DataOutput holds a valid word
ReadyOutput  input  1  consumer accepts DataOutput when ValidOutput&ReadyOutput

Behaviour:
- Reset (async, Reset=1):
  - State IDLE, Owner=B, BurstCnt=0.
  - ValidOutput=0, DataOutput=0, Select=0, ReadyA=ReadyB=0 while Reset high.
  - An in-flight output word is discarded.
- State: {IDLE, OWN_A, OWN_B}.
  - BurstCnt width = clog2(BURST_LEN+1).
  - LastOwner = the owner of the most recent grant; B after reset.
- CanLoad = !ValidOutput | ReadyOutput. Drain and load in the same cycle are allowed, giving full throughput.
- Grant (combinational, each cycle):
  - If in OWN_X and ValidX and BurstCnt<BURST_LEN, grant X (burst hold).
  - Otherwise arbitrate:
    - Only one valid: grant that one.
    - Both valid: grant the requester that is not LastOwner (A first after reset).
    - Neither valid: no grant, Select holds its previous value.
- Select = grant. ReadyX = CanLoad & (grant==X) & !Reset. The non-granted Ready is always 0.
- Transfer from X (ValidX & ReadyX), at the clock edge:
  - DataOutput <= DataX (via the Select mux); ValidOutput <= 1.
  - If X was already the owner, BurstCnt <= BurstCnt+1; else BurstCnt <= 1.
  - State <= OWN_X; LastOwner <= X.
- No transfer:
  - If ReadyOutput & ValidOutput, then ValidOutput <= 0 and DataOutput holds its value.
  - If the owner's Valid is low, state <= IDLE and BurstCnt <= 0.
- Latency: 1 cycle from accept to ValidOutput. No bubble on a grant switch, because the switch decision is made in the same cycle as the transfer.
- Backpressure (ValidOutput=1, ReadyOutput=0):
  - ReadyA=ReadyB=0.
  - DataOutput, state and BurstCnt are frozen.
  - The grant is still computed and Select still reflects it.
- BURST_LEN=1 gives strict A/B alternation when both are valid.
- Burst expiry with the other requester idle: the owner is re-granted and BurstCnt restarts at 1.
- The requester may drop Valid while not granted. The arbiter takes no action; there is no requester-side hold check.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined:
  - Both-valid arbitration always grants A.
  - Burst hold still applies to B: B keeps the grant until its burst expires or it idles.
  - At any arbitration point A wins, so B can starve under continuous ValidA. This is accepted by design.
- Undefined: round-robin as above.

Test Plan:
- Reset: assert Reset mid-stream with ValidOutput=1 → ValidOutput=0, DataOutput=0, Select=0, ReadyA=ReadyB=0 immediately (asynchronous). After release, A is granted first when both are valid.
- Single A: DataA=32'hFFFFFFFF, ValidA=1 for one cycle, ReadyOutput=1 → ReadyA=1 and Select=0 that cycle; next cycle DataOutput=32'hFFFFFFFF, ValidOutput=1.
- Both valid continuously, DataA=32'hFFFFFFFF, DataB=0, ReadyOutput=1, BURST_LEN=4 → DataOutput sequence 4×FFFFFFFF, 4×00000000, repeating; Select toggles every 4 cycles; ValidOutput stays 1 with no gap.
- Backpressure: ReadyOutput=0 while ValidOutput=1 for 5 cycles → ReadyA=ReadyB=0 and DataOutput stable. Raise ReadyOutput → stream resumes with no word lost or duplicated (scoreboard count matches).
- Early release: A owns, ValidA drops after 2 transfers with ValidB=1 → B transfers in the very next cycle with Select=1; B's BurstCnt starts at 1 and B gets a full 4-word burst.
- With ARB_FIXED_PRIORITY_EN, both valid continuously → all outputs are DataA and ReadyB stays 0. Without the macro the same stimulus gives the alternating 4/4 pattern.
